// File: rtl/alu_operand_sequencer.sv
// ---------------------------------------------------------------------------
// alu_operand_sequencer
//
// Drives the select lines of the ALU operand input multiplexer. A request
// carries one or two beats. A two-beat request runs a 16-bit operand through
// the 8-bit ALU: the low byte goes first, then the high byte. Each beat picks
// at most one high-side source and at most one low-side source. The select
// outputs are registered. Their polarity matches the mux pins, so lines marked
// in the *_INV_MASK parameters are active-low.
//
// Ports
//   CLK          clock, rising edge
//   Reset        synchronous, active-high
//   req_valid    request present
//   req_ready    request accepted when req_valid && req_ready
//   req_two      1 = two beats, 0 = one beat
//   req_hi0/lo0  beat-0 source codes (6'h3F = no source on that side)
//   req_hi1/lo1  beat-1 source codes (ignored for one-beat requests)
//   abort        flush the current operation, highest priority after Reset
//   beat_valid   selects are driving a valid beat
//   beat_second  current beat is beat 1
//   beat_ack     ALU consumed the current beat
//   sel_hi       high-side select lines, polarity per HI_INV_MASK
//   sel_lo       low-side select lines, polarity per LO_INV_MASK
//   busy         operation in flight
//   code_err     one-cycle pulse: accepted request had an out-of-range code
// ---------------------------------------------------------------------------
module alu_operand_sequencer #(
  parameter int                N_HI        = 16,
  parameter int                N_LO        = 42,
  parameter logic [N_HI-1:0]   HI_INV_MASK = 16'h68FB,
  parameter logic [N_LO-1:0]   LO_INV_MASK = 42'h0000004F1FF7
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_two,
  input  logic [5:0]      req_hi0,
  input  logic [5:0]      req_lo0,
  input  logic [5:0]      req_hi1,
  input  logic [5:0]      req_lo1,
  input  logic            abort,
  output logic            beat_valid,
  output logic            beat_second,
  input  logic            beat_ack,
  output logic [N_HI-1:0] sel_hi,
  output logic [N_LO-1:0] sel_lo,
  output logic            busy,
  output logic            code_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BEAT0 = 2'd1,
    S_BEAT1 = 2'd2
  } state_t;

  localparam logic [5:0] CODE_NONE = 6'h3F;

  state_t          state_q, state_d;
  logic            two_q, two_d;
  logic [5:0]      hi1_q, hi1_d;
  logic [5:0]      lo1_q, lo1_d;
  logic [N_HI-1:0] sel_hi_q, sel_hi_d;
  logic [N_LO-1:0] sel_lo_q, sel_lo_d;
  logic            code_err_q, code_err_d;
  logic            final_beat;
  logic            accept;

  // Out-of-range codes and CODE_NONE decode to no line. Driving nothing is
  // safer than aliasing onto a real source.
  function automatic logic [N_HI-1:0] dec_hi(input logic [5:0] code);
    logic [N_HI-1:0] r;
    r = '0;
    for (int i = 0; i < N_HI; i++) begin
      if (int'(code) == i) r[i] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [N_LO-1:0] dec_lo(input logic [5:0] code);
    logic [N_LO-1:0] r;
    r = '0;
    for (int i = 0; i < N_LO; i++) begin
      if (int'(code) == i) r[i] = 1'b1;
    end
    return r;
  endfunction

  // CODE_NONE is a legal "no source" request, not an error.
  function automatic logic code_bad(input logic [5:0] code, input int n);
    return (code != CODE_NONE) && (int'(code) >= n);
  endfunction

  // ---- state register ------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      two_q      <= 1'b0;
      sel_hi_q   <= HI_INV_MASK;
      sel_lo_q   <= LO_INV_MASK;
      code_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      two_q      <= two_d;
      sel_hi_q   <= sel_hi_d;
      sel_lo_q   <= sel_lo_d;
      code_err_q <= code_err_d;
    end
  end

  // The beat-1 codes are only read after an acceptance has loaded them, so
  // they need no reset.
  always_ff @(posedge CLK) begin
    hi1_q <= hi1_d;
    lo1_q <= lo1_d;
  end

  // ---- next-state logic ----------------------------------------------------
  always_comb begin
    state_d    = state_q;
    two_d      = two_q;
    hi1_d      = hi1_q;
    lo1_d      = lo1_q;
    sel_hi_d   = sel_hi_q;
    sel_lo_d   = sel_lo_q;
    code_err_d = 1'b0;
    accept     = req_valid && req_ready;

    if (abort) begin
      state_d  = S_IDLE;
      sel_hi_d = HI_INV_MASK;
      sel_lo_d = LO_INV_MASK;
    end else if (accept) begin
      // Accepting also covers the final beat's ack, which gives back-to-back
      // operations with no idle cycle between them.
      state_d    = S_BEAT0;
      two_d      = req_two;
      hi1_d      = req_hi1;
      lo1_d      = req_lo1;
      sel_hi_d   = dec_hi(req_hi0) ^ HI_INV_MASK;
      sel_lo_d   = dec_lo(req_lo0) ^ LO_INV_MASK;
      code_err_d = code_bad(req_hi0, N_HI) || code_bad(req_lo0, N_LO) ||
                   (req_two && (code_bad(req_hi1, N_HI) || code_bad(req_lo1, N_LO)));
    end else if (beat_ack && state_q != S_IDLE) begin
      if (state_q == S_BEAT0 && two_q) begin
        state_d  = S_BEAT1;
        sel_hi_d = dec_hi(hi1_q) ^ HI_INV_MASK;
        sel_lo_d = dec_lo(lo1_q) ^ LO_INV_MASK;
      end else begin
        state_d  = S_IDLE;
        sel_hi_d = HI_INV_MASK;
        sel_lo_d = LO_INV_MASK;
      end
    end
  end

  // ---- output logic --------------------------------------------------------
  always_comb begin
    final_beat  = (state_q == S_BEAT1) || (state_q == S_BEAT0 && !two_q);
    // Ready is held low while Reset is asserted, so no request is accepted
    // during reset.
    req_ready   = !Reset && !abort &&
                  ((state_q == S_IDLE) || (beat_ack && final_beat));
    beat_valid  = (state_q != S_IDLE);
    beat_second = (state_q == S_BEAT1);
    busy        = (state_q != S_IDLE);
  end

  assign sel_hi   = sel_hi_q;
  assign sel_lo   = sel_lo_q;
  assign code_err = code_err_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Testbench for alu_operand_sequencer. The reference model keeps a queue of
// the beats still to be presented; the head of the queue is the beat on the
// selects.
module tb_alu_operand_sequencer;

  localparam int          N_HI = 16;
  localparam int          N_LO = 42;
  localparam logic [15:0] HIM  = 16'h68FB;
  localparam logic [41:0] LOM  = 42'h0000004F1FF7;

  logic        CLK;
  logic        Reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_two;
  logic [5:0]  req_hi0, req_lo0, req_hi1, req_lo1;
  logic        abort;
  logic        beat_valid, beat_second, beat_ack;
  logic [15:0] sel_hi;
  logic [41:0] sel_lo;
  logic        busy, code_err;

  alu_operand_sequencer #(
    .N_HI(N_HI), .N_LO(N_LO), .HI_INV_MASK(HIM), .LO_INV_MASK(LOM)
  ) dut (
    .CLK(CLK), .Reset(Reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_two(req_two), .req_hi0(req_hi0), .req_lo0(req_lo0),
    .req_hi1(req_hi1), .req_lo1(req_lo1), .abort(abort),
    .beat_valid(beat_valid), .beat_second(beat_second), .beat_ack(beat_ack),
    .sel_hi(sel_hi), .sel_lo(sel_lo), .busy(busy), .code_err(code_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [5:0] hi;
    logic [5:0] lo;
    bit         second;
  } beat_t;

  beat_t mq[$];
  bit    m_err;
  int    pass_cnt  = 0;
  int    total_cnt = 0;

  function automatic logic [15:0] exp_hi(input logic [5:0] c);
    return (int'(c) < N_HI) ? (16'd1 << c) : 16'd0;
  endfunction

  function automatic logic [41:0] exp_lo(input logic [5:0] c);
    return (int'(c) < N_LO) ? (42'd1 << c) : 42'd0;
  endfunction

  function automatic bit bad(input logic [5:0] c, input int n);
    return (c != 6'h3F) && (int'(c) >= n);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic check_outputs();
    logic [15:0] eh;
    logic [41:0] el;
    bit          v;
    v  = (mq.size() > 0);
    eh = v ? (HIM ^ exp_hi(mq[0].hi)) : HIM;
    el = v ? (LOM ^ exp_lo(mq[0].lo)) : LOM;
    chk("beat_valid",  64'(beat_valid),  64'(v));
    chk("beat_second", 64'(beat_second), 64'(v && mq[0].second));
    chk("busy",        64'(busy),        64'(v));
    chk("sel_hi",      64'(sel_hi),      64'(eh));
    chk("sel_lo",      64'(sel_lo),      64'(el));
    chk("code_err",    64'(code_err),    64'(m_err));
  endtask

  // Check the combinational ready, advance the model by one clock edge, and
  // then check the registered outputs just after that edge.
  task automatic cycle();
    bit exp_ready;
    #1;
    exp_ready = !Reset && !abort &&
                (mq.size() == 0 || (beat_ack && mq.size() == 1));
    chk("req_ready", 64'(req_ready), 64'(exp_ready));
    m_err = 1'b0;
    if (Reset || abort) begin
      mq.delete();
    end else begin
      if (beat_ack && mq.size() > 0) void'(mq.pop_front());
      if (req_valid && exp_ready) begin
        mq.push_back('{req_hi0, req_lo0, 1'b0});
        if (req_two) mq.push_back('{req_hi1, req_lo1, 1'b1});
        m_err = bad(req_hi0, N_HI) || bad(req_lo0, N_LO) ||
                (req_two && (bad(req_hi1, N_HI) || bad(req_lo1, N_LO)));
      end
    end
    @(posedge CLK);
    #1;
    check_outputs();
  endtask

  task automatic quiet();
    req_valid = 1'b0; beat_ack = 1'b0; abort = 1'b0; req_two = 1'b0;
  endtask

  task automatic request(input bit two, input logic [5:0] h0, l0, h1, l1);
    req_valid = 1'b1; req_two = two;
    req_hi0 = h0; req_lo0 = l0; req_hi1 = h1; req_lo1 = l1;
  endtask

  // Mostly legal codes, with some "no source" codes and some out-of-range codes.
  function automatic logic [5:0] rcode(input int n);
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 6)      return 6'($urandom_range(0, n - 1));
    else if (r < 8) return 6'h3F;
    else            return 6'($urandom_range(n, 62));
  endfunction

  initial begin
    Reset = 1'b1;
    quiet();
    request(1'b0, 6'd0, 6'd0, 6'd0, 6'd0);
    req_valid = 1'b0;
    @(posedge CLK);
    cycle();
    cycle();
    chk("rst_sel_hi", 64'(sel_hi), 64'(HIM));
    chk("rst_sel_lo", 64'(sel_lo), 64'(LOM));
    chk("rst_ready",  64'(req_ready), 64'd0);
    Reset = 1'b0;

    // One-beat request: hi = A, lo = C.
    request(1'b0, 6'd0, 6'd3, 6'd0, 6'd0);
    cycle();
    chk("t1_sel_hi", 64'(sel_hi), 64'(HIM ^ 16'h0001));
    chk("t1_sel_lo", 64'(sel_lo), 64'(LOM ^ (42'd1 << 3)));
    chk("t1_valid",  64'(beat_valid), 64'd1);
    quiet(); beat_ack = 1'b1;
    cycle();

    // Two-beat request: beat 0 lo = L, beat 1 lo = H, both hi = BC.
    request(1'b1, 6'd8, 6'd7, 6'd8, 6'd6);
    beat_ack = 1'b0;
    cycle();
    chk("t2_b0_lo", 64'(sel_lo), 64'(LOM ^ (42'd1 << 7)));
    chk("t2_b0_second", 64'(beat_second), 64'd0);
    quiet(); beat_ack = 1'b1;
    cycle();
    chk("t2_b1_lo", 64'(sel_lo), 64'(LOM ^ (42'd1 << 6)));
    chk("t2_b1_hi", 64'(sel_hi), 64'(HIM ^ (16'd1 << 8)));
    chk("t2_b1_second", 64'(beat_second), 64'd1);
    cycle();
    chk("t2_idle", 64'(busy), 64'd0);

    // Hold a beat without ack, then ack it with a new request in the same
    // cycle; the new beat must follow with no bubble.
    quiet();
    request(1'b0, 6'd1, 6'd2, 6'd0, 6'd0);
    cycle();
    quiet();
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("t3_hold_lo", 64'(sel_lo), 64'(LOM ^ (42'd1 << 2)));
    end
    request(1'b0, 6'd2, 6'd4, 6'd0, 6'd0);
    beat_ack = 1'b1;
    cycle();
    chk("t3_nobubble_valid", 64'(beat_valid), 64'd1);
    chk("t3_nobubble_lo", 64'(sel_lo), 64'(LOM ^ (42'd1 << 4)));
    quiet(); beat_ack = 1'b1;
    cycle();

    // Out-of-range low code.
    request(1'b0, 6'd3, 6'd50, 6'd0, 6'd0);
    beat_ack = 1'b0;
    cycle();
    chk("t4_err", 64'(code_err), 64'd1);
    chk("t4_lo_none", 64'(sel_lo), 64'(LOM));
    chk("t4_valid", 64'(beat_valid), 64'd1);
    quiet();
    cycle();
    chk("t4_err_pulse", 64'(code_err), 64'd0);
    beat_ack = 1'b1;
    cycle();

    // Abort during beat 1 while ack and a new request are both present.
    request(1'b1, 6'd4, 6'd5, 6'd5, 6'd4);
    beat_ack = 1'b0;
    cycle();
    quiet(); beat_ack = 1'b1;
    cycle();
    request(1'b0, 6'd6, 6'd6, 6'd0, 6'd0);
    beat_ack = 1'b1; abort = 1'b1;
    cycle();
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_valid", 64'(beat_valid), 64'd0);
    quiet();
    cycle();

    // Reset during beat 0, then a beat that selects no source on either side.
    request(1'b0, 6'd7, 6'd8, 6'd0, 6'd0);
    cycle();
    quiet(); Reset = 1'b1;
    cycle();
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_lo", 64'(sel_lo), 64'(LOM));
    Reset = 1'b0;
    request(1'b0, 6'h3F, 6'h3F, 6'd0, 6'd0);
    cycle();
    chk("t6_none_valid", 64'(beat_valid), 64'd1);
    chk("t6_none_hi", 64'(sel_hi), 64'(HIM));
    chk("t6_none_err", 64'(code_err), 64'd0);
    quiet(); beat_ack = 1'b1;
    cycle();

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      req_valid = ($urandom_range(0, 9) < 6);
      req_two   = $urandom_range(0, 1) == 1;
      req_hi0   = rcode(N_HI);
      req_lo0   = rcode(N_LO);
      req_hi1   = rcode(N_HI);
      req_lo1   = rcode(N_LO);
      beat_ack  = $urandom_range(0, 1) == 1;
      abort     = ($urandom_range(0, 19) == 0);
      Reset     = ($urandom_range(0, 49) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
